// File: rtl/mips_gpio_bank_pkg.sv
// Shared register map and register-select encoding for the MIPS GPIO bank.
// Offsets are within one 16-byte port block; IRQ_EN follows the last port block.
package mips_gpio_pkg;

    localparam logic [3:0] OFS_OUT     = 4'h0;
    localparam logic [3:0] OFS_DIR     = 4'h4;
    localparam logic [3:0] OFS_IN      = 4'h8;
    localparam logic [3:0] OFS_EDGE    = 4'hC;
    localparam int         PORT_STRIDE = 16;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_DIR,
        SEL_IN,
        SEL_EDGE,
        SEL_IRQ_EN
    } reg_sel_e;

    function automatic reg_sel_e port_reg_sel(input logic [3:0] ofs);
        reg_sel_e sel;
        case (ofs)
            OFS_OUT:  sel = SEL_OUT;
            OFS_DIR:  sel = SEL_DIR;
            OFS_IN:   sel = SEL_IN;
            OFS_EDGE: sel = SEL_EDGE;
            default:  sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mips_gpio_bank_sync_edge.sv
// Two-flop pin synchroniser with rising-edge detect on the synchronised value.
// Pins whose mask bit is set (driven outputs) never report a rise.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] pin_p0;
    logic [WIDTH-1:0] pin_p1;
    logic [WIDTH-1:0] prev_p2;

    // prev_p2 clears with the synchroniser, so a pin held high through reset
    // is reported once when its value emerges from the second stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pin_p0  <= '0;
            pin_p1  <= '0;
            prev_p2 <= '0;
        end else begin
            pin_p0  <= pin;
            pin_p1  <= pin_p0;
            prev_p2 <= pin_p1;
        end
    end

    assign sync = pin_p1;
    assign rise = pin_p1 & ~prev_p2 & ~mask;

endmodule

// File: rtl/mips_gpio_bank.sv
// Memory-mapped GPIO bank for a MIPS bus: per-port OUT/DIR/IN/EDGE registers
// plus a shared IRQ_EN register, registered read data and address-error pulse.
module mips_gpio_bank
    import mips_gpio_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    PORT_WIDTH = 8,
    parameter int                    NUM_PORTS  = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            we,
    input  logic                            re,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            addr_err,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe,
    output logic                            irq
);

    localparam int                    PW      = PORT_WIDTH;
    localparam int                    BW      = NUM_PORTS * PORT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IRQ_OFS = ADDR_WIDTH'(PORT_STRIDE * NUM_PORTS);

    logic [BW-1:0]         out_q;
    logic [BW-1:0]         dir_q;
    logic [BW-1:0]         edge_q;
    logic [BW-1:0]         edge_clr;
    logic [BW-1:0]         edge_d;
    logic [BW-1:0]         sync_all;
    logic [BW-1:0]         rise_all;
    logic [NUM_PORTS-1:0]  irq_en_q;
    logic [NUM_PORTS-1:0]  edge_any;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] blk;
    reg_sel_e              sel;
    logic [2:0]            sel_port;
    logic                  mapped;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_bits;

    assign unused_bits = ^wdata;

    // Offset arithmetic wraps, so addresses below BASE_ADDR land far out of range.
    always_comb begin
        offset   = addr - BASE_ADDR;
        blk      = offset / ADDR_WIDTH'(PORT_STRIDE);
        sel      = SEL_NONE;
        sel_port = '0;
        if (addr[1:0] == 2'b00) begin
            if (offset == IRQ_OFS) begin
                sel = SEL_IRQ_EN;
            end else if (blk < ADDR_WIDTH'(NUM_PORTS)) begin
                sel      = port_reg_sel(offset[3:0]);
                sel_port = blk[2:0];
            end
        end
    end

    assign mapped = (sel != SEL_NONE);

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            gpio_sync_edge #(
                .WIDTH (PW)
            ) u_sync_edge (
                .clk   (clk),
                .reset (reset),
                .pin   (gpio_in[gp*PW +: PW]),
                .mask  (dir_q[gp*PW +: PW]),
                .sync  (sync_all[gp*PW +: PW]),
                .rise  (rise_all[gp*PW +: PW])
            );
        end
    endgenerate

    // A fresh edge is OR-ed in after the W1C mask so a coincident set wins.
    always_comb begin
        edge_clr = '0;
        edge_any = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (we && sel == SEL_EDGE && sel_port == 3'(p)) begin
                edge_clr[p*PW +: PW] = wdata[PW-1:0];
            end
            edge_any[p] = |edge_q[p*PW +: PW];
        end
        edge_d = (edge_q & ~edge_clr) | rise_all;
    end

    always_comb begin
        rd_val = '0;
        if (sel == SEL_IRQ_EN) begin
            rd_val = DATA_WIDTH'(irq_en_q);
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sel_port == 3'(p)) begin
                    case (sel)
                        SEL_OUT:  rd_val = DATA_WIDTH'(out_q[p*PW +: PW]);
                        SEL_DIR:  rd_val = DATA_WIDTH'(dir_q[p*PW +: PW]);
                        SEL_IN:   rd_val = DATA_WIDTH'(sync_all[p*PW +: PW]);
                        SEL_EDGE: rd_val = DATA_WIDTH'(edge_q[p*PW +: PW]);
                        default:  rd_val = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            dir_q    <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            rdata    <= '0;
            addr_err <= 1'b0;
            irq      <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (we && sel_port == 3'(p)) begin
                    if (sel == SEL_OUT) out_q[p*PW +: PW] <= wdata[PW-1:0];
                    if (sel == SEL_DIR) dir_q[p*PW +: PW] <= wdata[PW-1:0];
                end
            end
            if (we && sel == SEL_IRQ_EN) irq_en_q <= wdata[NUM_PORTS-1:0];
            edge_q   <= edge_d;
            if (re) rdata <= rd_val;
            addr_err <= (we || re) && !mapped;
            irq      <= |(irq_en_q & edge_any);
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule
